wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 73 +++++++
 tb/tb_wb_regfile.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MEM/WB pipeline latch feeding a 32x32 register file with write-through bypass.
// Register 0 is hardwired to zero; reads are combinational on both ports.
module wb_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic        reg_dst,
  input  logic        reg_wr,
  input  logic        mem_to_reg,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  logic        validQ;
  logic        regWrQ;
  logic [4:0]  addrQ;
  logic [31:0] dataQ;
  logic [31:0] regArray [32];

  logic [4:0]  capAddr;
  logic [31:0] capData;

  assign capAddr = reg_dst ? mem_inst[15:11] : mem_inst[20:16];
  assign capData = mem_to_reg ? mem_read_data : mem_alu_result;

  // Priority: reset, then flush (bubble), then stall (hold), then capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      validQ <= 1'b0;
      regWrQ <= 1'b0;
      addrQ  <= 5'd0;
      dataQ  <= 32'd0;
    end else if (!stall) begin
      validQ <= 1'b1;
      regWrQ <= reg_wr;
      addrQ  <= capAddr;
      dataQ  <= capData;
    end
  end

  assign wb_valid = validQ;
  assign wb_addr  = addrQ;
  assign wb_data  = dataQ;
  assign wb_we    = validQ & regWrQ & (addrQ != 5'd0);

  // The array write uses pre-edge latch contents, so a pending write still
  // commits on a flush edge; wb_we excludes register 0 so it is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        regArray[k] <= 32'd0;
      end
    end else if (wb_we) begin
      regArray[addrQ] <= dataQ;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'd0 :
                   (wb_we && (rs_addr == addrQ)) ? dataQ : regArray[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 :
                   (wb_we && (rt_addr == addrQ)) ? dataQ : regArray[rt_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations are queued when stimulus is
// driven and popped when the DUT output is sampled, 1 ns after the rising edge.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] mem_inst;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic        reg_dst;
  logic        reg_wr;
  logic        mem_to_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] exp_q [$];
  logic [31:0] model [32];
  int          checks;
  int          errors;

  wb_regfile dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_inst(mem_inst), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .reg_dst(reg_dst), .reg_wr(reg_wr),
    .mem_to_reg(mem_to_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic dst,
                       input logic wr, input logic m2r);
    mem_inst       = inst;
    mem_alu_result = alu;
    mem_read_data  = rdata;
    reg_dst        = dst;
    reg_wr         = wr;
    mem_to_reg     = m2r;
  endtask

  task automatic drive_idle();
    drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // R-type with rt field = 2 so a wrong destination select shows up.
  function automatic logic [31:0] rtype(input logic [4:0] rd);
    return {6'h00, 5'd1, 5'd2, rd, 11'h000};
  endfunction

  // I-type load whose rd bit field holds 12 to catch a wrong select.
  function automatic logic [31:0] itype(input logic [4:0] rt);
    return {6'h23, 5'd1, rt, 5'd12, 11'h040};
  endfunction

  // scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_outputs(input logic v, input logic we,
                                input logic [4:0] a, input logic [31:0] d);
    expect_val({31'd0, v});
    expect_val({31'd0, we});
    expect_val({27'd0, a});
    expect_val(d);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wb_valid"}, {31'd0, wb_valid});
    chk({tag, ".wb_we"},    {31'd0, wb_we});
    chk({tag, ".wb_addr"},  {27'd0, wb_addr});
    chk({tag, ".wb_data"},  wb_data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rs_addr = 5'd3; rt_addr = 5'd17;
    drive_idle();

    // reset state
    tick(); tick();
    expect_outputs(1'b0, 1'b0, 5'd0, 32'd0);
    expect_val(32'd0);
    expect_val(32'd0);
    check_outputs("reset");
    chk("reset.rs_data", rs_data);
    chk("reset.rt_data", rt_data);
    reset = 1'b0;

    // R-type: rd=5 <- 0x1234, read through the bypass before commit
    drive(rtype(5'd5), 32'h1234, 32'h0BAD_0BAD, 1'b1, 1'b1, 1'b0);
    rs_addr = 5'd5;
    expect_outputs(1'b1, 1'b1, 5'd5, 32'h1234);
    expect_val(32'h1234);
    tick();
    check_outputs("rtype");
    chk("rtype.bypass", rs_data);
    drive_idle();
    expect_val(32'h0);
    expect_val(32'h1234);
    tick();
    model[5] = 32'h1234;
    chk("rtype.idle_we", {31'd0, wb_we});
    chk("rtype.array5", rs_data);

    // Load: rt=9 <- read data, both ports on the same register
    drive(itype(5'd9), 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    rs_addr = 5'd9; rt_addr = 5'd9;
    expect_outputs(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    expect_val(32'hDEAD_BEEF);
    expect_val(32'hDEAD_BEEF);
    tick();
    check_outputs("load");
    chk("load.rt_bypass", rt_data);
    chk("load.rs_same", rs_data);

    // Write to $0 is suppressed
    rs_addr = 5'd0;
    settle();
    expect_val(32'd0);
    chk("zero.before", rs_data);
    drive(rtype(5'd0), 32'hFFFF, 32'd0, 1'b1, 1'b1, 1'b0);
    expect_outputs(1'b1, 1'b0, 5'd0, 32'hFFFF);
    expect_val(32'd0);
    tick();
    model[9] = 32'hDEAD_BEEF;
    check_outputs("zero");
    chk("zero.rs_data", rs_data);
    drive_idle();
    expect_val(32'd0);
    tick();
    chk("zero.after", rs_data);

    // Stall for 3 cycles holding a write to $7
    drive(rtype(5'd7), 32'hA5, 32'd0, 1'b1, 1'b1, 1'b0);
    expect_outputs(1'b1, 1'b1, 5'd7, 32'hA5);
    tick();
    check_outputs("stall.cap");
    stall = 1'b1;
    drive(rtype(5'd8), 32'h0BAD, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      expect_outputs(1'b1, 1'b1, 5'd7, 32'hA5);
      tick();
      check_outputs($sformatf("stall.c%0d", c));
    end
    stall = 1'b0;
    drive_idle();
    tick();
    model[7] = 32'hA5;
    for (int k = 0; k < 32; k++) expect_val(model[k]);
    for (int k = 0; k < 32; k++) begin
      rs_addr = k[4:0];
      settle();
      chk($sformatf("stall.reg%0d", k), rs_data);
    end

    // Flush and stall together while a write to $12 is pending
    drive(rtype(5'd12), 32'h777, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    flush = 1'b1; stall = 1'b1;
    drive(rtype(5'd13), 32'h888, 32'd0, 1'b1, 1'b1, 1'b0);
    rs_addr = 5'd12; rt_addr = 5'd13;
    expect_outputs(1'b0, 1'b0, 5'd0, 32'd0);
    expect_val(32'h777);
    expect_val(32'd0);
    tick();
    model[12] = 32'h777;
    check_outputs("flush");
    chk("flush.commit12", rs_data);
    chk("flush.no13", rt_data);
    flush = 1'b0; stall = 1'b0;
    drive_idle();
    tick();

    // Commit $3, then reset while a write to $4 is pending (stall also high)
    drive(rtype(5'd3), 32'h55, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_idle();
    rs_addr = 5'd3;
    expect_val(32'h55);
    tick();
    chk("rst.pre3", rs_data);
    drive(rtype(5'd4), 32'h66, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b1; stall = 1'b1;
    rs_addr = 5'd3; rt_addr = 5'd4;
    expect_outputs(1'b0, 1'b0, 5'd0, 32'd0);
    expect_val(32'd0);
    expect_val(32'd0);
    tick();
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    check_outputs("rst");
    chk("rst.array3", rs_data);
    chk("rst.array4", rt_data);
    reset = 1'b0; stall = 1'b0;
    drive_idle();
    rs_addr = 5'd5; rt_addr = 5'd9;
    expect_val(model[5]);
    expect_val(model[9]);
    settle();
    chk("rst.array5", rs_data);
    chk("rst.array9", rt_data);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard.drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
